// File: rtl/myfilter_i2c_master.sv
// Write-only I2C master: sends one frame of {I2C_ADDR, W} followed by NBYTES host bytes.
// Define MYFILTER_I2CM_ACK_CHECK_EN to abort a frame on a NACK; otherwise ACK slots are generated but ignored.
module myfilter_i2c_master #(
  parameter logic [6:0] I2C_ADDR = 7'b1111000,
  parameter int         NBYTES   = 20,
  parameter int         SCL_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic [7:0] data_in,
  output logic       byte_ack_out,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       nack_out
);

  localparam int DIV_W  = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;
  localparam int BYTE_W = $clog2(NBYTES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCL_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        phase_q;
  logic [3:0]        bit_q;
  logic [BYTE_W-1:0] byte_q;
  logic [7:0]        shift_q;

  logic phase_end, slot_end, last_bit, accept, scl_mid, abort;

  assign phase_end = (div_q == DIV_LAST);
  assign slot_end  = phase_end && (phase_q == 2'd3);
  assign last_bit  = (bit_q == 4'd7);
  assign accept    = (state_q == IDLE) && start_in;
  assign scl_mid   = phase_q[0] ^ phase_q[1];

`ifdef MYFILTER_I2CM_ACK_CHECK_EN
  logic nack_q;

  // ACK is sampled once, on the first cycle of phase 2 while SCL is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nack_q <= 1'b0;
    end else if (accept) begin
      nack_q <= 1'b0;
    end else if ((state_q == AACK || state_q == DACK) && phase_q == 2'd2 && div_q == '0 && sda_in) begin
      nack_q <= 1'b1;
    end
  end

  assign abort    = nack_q;
  assign nack_out = nack_q;
`else
  assign abort    = 1'b0;
  assign nack_out = 1'b0;
`endif

  // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = START;
      START:   if (slot_end) state_d = ADDR;
      ADDR:    if (slot_end && last_bit) state_d = AACK;
      AACK:    if (slot_end) state_d = abort ? STOP : DATA;
      DATA:    if (slot_end && last_bit) state_d = DACK;
      DACK:    if (slot_end) state_d = (abort || byte_q == BYTE_LAST) ? STOP : DATA;
      STOP:    if (slot_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= 2'd0;
      bit_q   <= 4'd0;
      byte_q  <= '0;
      shift_q <= 8'd0;
    end else begin
      if (state_q == IDLE) begin
        div_q   <= '0;
        phase_q <= 2'd0;
      end else begin
        div_q <= phase_end ? '0 : div_q + 1'b1;
        if (phase_end) phase_q <= phase_q + 2'd1;
      end

      if (accept) begin
        bit_q <= 4'd0;
      end else if (slot_end) begin
        if ((state_q == ADDR || state_q == DATA) && !last_bit) bit_q <= bit_q + 4'd1;
        else                                                   bit_q <= 4'd0;
      end

      if (accept) begin
        byte_q <= '0;
      end else if (state_q == DACK && slot_end && byte_q != BYTE_LAST) begin
        byte_q <= byte_q + 1'b1;
      end

      // Address is preloaded at the end of START; data is latched on the byte_ack cycle.
      if (state_q == START && slot_end) begin
        shift_q <= {I2C_ADDR, 1'b0};
      end else if (byte_ack_out) begin
        shift_q <= data_in;
      end else if ((state_q == ADDR || state_q == DATA) && slot_end) begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
    end
  end

  assign byte_ack_out = (state_q == DATA) && (bit_q == 4'd0) && (phase_q == 2'd0) && (div_q == '0);
  assign busy_out     = (state_q != IDLE);
  assign done_out     = (state_q == STOP) && slot_end;

  // Line levels decode directly from registered state, so reset forces them released at once.
  always_comb begin
    scl_out = 1'b1;
    sda_out = 1'b1;
    unique case (state_q)
      START: begin
        scl_out = (phase_q != 2'd3);
        sda_out = (phase_q == 2'd0);
      end
      ADDR: begin
        scl_out = scl_mid;
        sda_out = shift_q[7];
      end
      DATA: begin
        scl_out = scl_mid;
        sda_out = byte_ack_out ? data_in[7] : shift_q[7];
      end
      AACK, DACK: begin
        scl_out = scl_mid;
        sda_out = 1'b1;
      end
      STOP: begin
        scl_out = (phase_q != 2'd0);
        sda_out = phase_q[1];
      end
      default: begin
        scl_out = 1'b1;
        sda_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_myfilter_i2c_master.sv
// Directed bench for myfilter_i2c_master: a table of whole-frame scenarios driven by a small I2C slave model.
// Scenario set follows whether MYFILTER_I2CM_ACK_CHECK_EN is defined.
module tb_myfilter_i2c_master;

  localparam int NBYTES  = 20;
  localparam int SCL_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_in;
  logic [7:0] data_in;
  logic       byte_ack_out, scl_out, sda_out, sda_in;
  logic       busy_out, done_out, nack_out;

  int checks = 0;
  int errors = 0;

  myfilter_i2c_master #(
    .I2C_ADDR(7'b1111000),
    .NBYTES  (NBYTES),
    .SCL_DIV (SCL_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_in    (start_in),
    .data_in     (data_in),
    .byte_ack_out(byte_ack_out),
    .scl_out     (scl_out),
    .sda_out     (sda_out),
    .sda_in      (sda_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .nack_out    (nack_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nack_at;    // byte whose ACK slot the slave NACKs (0 = address), -1 none
    bit hold_high;  // slave never pulls SDA low
    int pulse_at;   // cycle of a stray start_in pulse, 0 none
    int rst_at;     // assert rst_n right after this byte_ack pulse, 0 none
    int exp_acks;
    int exp_done;
    bit exp_nack;
    int exp_rises;
  } frame_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(32'h3C ^ (i * 37));
  endfunction

  task automatic run_frame(input frame_t f);
    int   acks = 0, dones = 0, rises = 0, done_cyc = 0, bad_rel = 0, slot;
    logic prev_scl;
    bit   pending = 1'b0, seen_done = 1'b0;
    logic [7:0] rx [0:NBYTES];
    for (int k = 0; k <= NBYTES; k++) rx[k] = 8'h00;
    data_in = pat(0);
    sda_in  = 1'b1;
    @(negedge clk);
    start_in = 1'b1;
    rst_n    = 1'b1;
    prev_scl = scl_out;
    for (int cyc = 1; cyc <= 4000 && !seen_done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start_in = 1'b0;
        check("busy_on_start", int'(busy_out), 1);
        check("nack_cleared", int'(nack_out), 0);
      end
      if (f.pulse_at != 0 && cyc == f.pulse_at)     start_in = 1'b1;
      if (f.pulse_at != 0 && cyc == f.pulse_at + 1) start_in = 1'b0;
      if (byte_ack_out) begin
        acks++;
        pending = 1'b1;
        if (f.rst_at != 0 && acks == f.rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_scl", int'(scl_out), 1);
          check("rst_sda", int'(sda_out), 1);
          check("rst_busy", int'(busy_out), 0);
          check("rst_byte_ack", int'(byte_ack_out), 0);
          check("rst_done", int'(done_out), 0);
          sda_in = 1'b1;
          return;
        end
      end else if (pending) begin
        data_in = pat(acks);
        pending = 1'b0;
      end
      if (scl_out && !prev_scl) begin
        slot = rises;
        rises++;
        if (slot % 9 == 8) begin
          if (!sda_out) bad_rel++;
          sda_in = (f.nack_at == slot / 9 || f.hold_high) ? 1'b1 : 1'b0;
        end else if (slot / 9 <= NBYTES) begin
          rx[slot/9] = {rx[slot/9][6:0], sda_out};
        end
      end else if (!scl_out && prev_scl) begin
        sda_in = 1'b1;
      end
      prev_scl = scl_out;
      if (done_out) begin
        dones++;
        done_cyc  = cyc;
        seen_done = 1'b1;
      end
    end
    if (!seen_done) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("done_cycle", done_cyc, f.exp_done);
    check("byte_ack_count", acks, f.exp_acks);
    check("scl_rises", rises, f.exp_rises);
    check("nack_at_done", int'(nack_out), int'(f.exp_nack));
    check("ack_slot_released", bad_rel, 0);
    check("addr_byte", int'(rx[0]), 32'hF0);
    for (int k = 1; k <= f.exp_acks; k++) check($sformatf("data_byte_%0d", k), int'(rx[k]), int'(pat(k - 1)));
    @(negedge clk);
    check("busy_after_done", int'(busy_out), 0);
    for (int k = 0; k < 20; k++) begin
      if (done_out) dones++;
      @(negedge clk);
    end
    check("single_done", dones, 1);
    check("idle_busy", int'(busy_out), 0);
    check("nack_held", int'(nack_out), int'(f.exp_nack));
    check("idle_scl", int'(scl_out), 1);
    check("idle_sda", int'(sda_out), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    frame_t tbl [6];
    int     ntbl;
    rst_n    = 1'b0;
    start_in = 1'b0;
    data_in  = 8'h00;
    sda_in   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_scl", int'(scl_out), 1);
    check("reset_sda", int'(sda_out), 1);
    check("reset_busy", int'(busy_out), 0);
    check("reset_done", int'(done_out), 0);
    check("reset_nack", int'(nack_out), 0);
    check("reset_byte_ack", int'(byte_ack_out), 0);

    // Full frame: 16*(2+9*21) = 3056 cycles; address NACK: 16*11 = 176; NACK on byte 3: 16*38 = 608.
    tbl[0] = '{nack_at: -1, hold_high: 1'b0, pulse_at: 0,   rst_at: 0, exp_acks: 20, exp_done: 3056, exp_nack: 1'b0, exp_rises: 190};
    tbl[1] = '{nack_at: -1, hold_high: 1'b0, pulse_at: 100, rst_at: 0, exp_acks: 20, exp_done: 3056, exp_nack: 1'b0, exp_rises: 190};
    tbl[2] = '{nack_at: -1, hold_high: 1'b0, pulse_at: 0,   rst_at: 5, exp_acks: 0,  exp_done: 0,    exp_nack: 1'b0, exp_rises: 0};
    tbl[3] = '{nack_at: -1, hold_high: 1'b0, pulse_at: 0,   rst_at: 0, exp_acks: 20, exp_done: 3056, exp_nack: 1'b0, exp_rises: 190};
`ifdef MYFILTER_I2CM_ACK_CHECK_EN
    tbl[4] = '{nack_at: 0,  hold_high: 1'b0, pulse_at: 0,   rst_at: 0, exp_acks: 0,  exp_done: 176,  exp_nack: 1'b1, exp_rises: 10};
    tbl[5] = '{nack_at: 3,  hold_high: 1'b0, pulse_at: 0,   rst_at: 0, exp_acks: 3,  exp_done: 608,  exp_nack: 1'b1, exp_rises: 37};
    ntbl = 6;
`else
    tbl[4] = '{nack_at: -1, hold_high: 1'b1, pulse_at: 0,   rst_at: 0, exp_acks: 20, exp_done: 3056, exp_nack: 1'b0, exp_rises: 190};
    ntbl = 5;
`endif

    for (int i = 0; i < ntbl; i++) run_frame(tbl[i]);

`ifdef MYFILTER_I2CM_ACK_CHECK_EN
    // A fresh start must clear the sticky NACK left by the previous frame.
    run_frame(tbl[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
